// File: rtl/note_seq_pkg.sv
// Shared types and step-word field layout for the note sequencer.
// Step word: [7:6] voice, [5] oct_down, [4] oct_up, [3] tremolo, [2:0] duration in ticks.
package note_seq_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } seq_state_e;

    localparam int VOICE_MSB    = 7;
    localparam int VOICE_LSB    = 6;
    localparam int OCT_DOWN_BIT = 5;
    localparam int OCT_UP_BIT   = 4;
    localparam int TREM_BIT     = 3;
    localparam int DUR_MSB      = 2;
    localparam int DUR_LSB      = 0;

    localparam logic [1:0] VOICE_REST = 2'b00;
    localparam logic [1:0] VOICE_CLK1 = 2'b01;
    localparam logic [1:0] VOICE_CLK2 = 2'b10;
    localparam logic [1:0] VOICE_BOTH = 2'b11;

    localparam logic [2:0] DUR_END = 3'd0;

    typedef struct packed {
        logic [1:0] voice;
        logic       oct_down;
        logic       oct_up;
        logic       tremolo;
        logic [2:0] dur;
    } step_t;

    function automatic step_t unpack_step(input logic [7:0] w);
        step_t s;
        s.voice    = w[VOICE_MSB:VOICE_LSB];
        s.oct_down = w[OCT_DOWN_BIT];
        s.oct_up   = w[OCT_UP_BIT];
        s.tremolo  = w[TREM_BIT];
        s.dur      = w[DUR_MSB:DUR_LSB];
        return s;
    endfunction

    // Map the voice field onto the two tone-clock gates (bit0 = clock 1, bit1 = clock 2).
    function automatic logic [1:0] voice_gates(input logic [1:0] v);
        logic [1:0] g;
        case (v)
            VOICE_REST: g = 2'b00;
            VOICE_CLK1: g = 2'b01;
            VOICE_CLK2: g = 2'b10;
            VOICE_BOTH: g = 2'b11;
            default:    g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Tempo prescaler: counts TICK_DIV clk cycles and flags the last one of each period.
// A synchronous clear restarts the period so a new step begins on a tick boundary.
module seq_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Step-pattern sequencer driving the tone-feature control pins from a small step memory.
// Optional macro NOTE_SEQ_ARTIC_EN silences the voices during the final tick of steps of duration >= 2.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 1000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    output logic [1:0]               voice_en,
    output logic                     octave_dena,
    output logic                     octave_uena,
    output logic                     tremolo_ena,
    output logic                     busy,
    output logic [$clog2(DEPTH)-1:0] step_idx,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0] mem_q [DEPTH];

    seq_state_e state_q, state_d;
    logic [1:0]    voice_q, voice_d;
    logic          odn_q, odn_d;
    logic          oup_q, oup_d;
    logic          trem_q, trem_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [2:0]    dur_q, dur_d;
    logic [2:0]    tcnt_q, tcnt_d;

    logic          tick_s;
    logic          fetch_s;
    logic          idle_s;
    logic          step_last_s;
    logic          pat_end_s;
    logic [AW-1:0] fetch_idx_s;
    logic [AW-1:0] next_idx_s;
    step_t         fetch_step_s;
    step_t         next_step_s;

    seq_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (fetch_s),
        .tick (tick_s)
    );

    assign next_idx_s   = idx_q + AW'(1);
    assign next_step_s  = unpack_step(mem_q[next_idx_s]);
    assign fetch_step_s = unpack_step(mem_q[fetch_idx_s]);

    // Host writes land only while idle so a running pattern can never change under playback.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == ST_IDLE)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        voice_d     = voice_q;
        odn_d       = odn_q;
        oup_d       = oup_q;
        trem_d      = trem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        idx_d       = idx_q;
        dur_d       = dur_q;
        tcnt_d      = tcnt_q;
        fetch_s     = 1'b0;
        idle_s      = 1'b0;
        fetch_idx_s = '0;
        step_last_s = tick_s && (tcnt_q == (dur_q - 3'd1));
        pat_end_s   = (idx_q == AW'(DEPTH - 1)) || (next_step_s.dur == DUR_END);

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    fetch_s = 1'b1;
                end else begin
                    idle_s = 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    idle_s = 1'b1;
                end else if ((dur_q == DUR_END) || step_last_s) begin
                    // An end marker only ever sounds (silently) when it sits in slot 0.
                    if ((dur_q != DUR_END) && !pat_end_s) begin
                        fetch_s     = 1'b1;
                        fetch_idx_s = next_idx_s;
                    end else if (loop_en) begin
                        fetch_s = 1'b1;
                    end else begin
                        idle_s = 1'b1;
                        done_d = 1'b1;
                    end
                end else if (tick_s) begin
                    tcnt_d = tcnt_q + 3'd1;
`ifdef NOTE_SEQ_ARTIC_EN
                    if ((dur_q >= 3'd2) && (tcnt_q == (dur_q - 3'd2))) begin
                        voice_d = VOICE_REST;
                    end else begin
                        voice_d = voice_q;
                    end
`endif
                end else begin
                    tcnt_d = tcnt_q;
                end
            end
            default: begin
                idle_s = 1'b1;
            end
        endcase

        if (fetch_s) begin
            state_d = ST_PLAY;
            busy_d  = 1'b1;
            idx_d   = fetch_idx_s;
            dur_d   = fetch_step_s.dur;
            tcnt_d  = 3'd0;
            if (fetch_step_s.dur == DUR_END) begin
                voice_d = VOICE_REST;
                odn_d   = 1'b0;
                oup_d   = 1'b0;
                trem_d  = 1'b0;
            end else begin
                voice_d = voice_gates(fetch_step_s.voice);
                odn_d   = fetch_step_s.oct_down && !fetch_step_s.oct_up;
                oup_d   = fetch_step_s.oct_up && !fetch_step_s.oct_down;
                trem_d  = fetch_step_s.tremolo;
            end
        end else if (idle_s) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            voice_d = VOICE_REST;
            odn_d   = 1'b0;
            oup_d   = 1'b0;
            trem_d  = 1'b0;
            idx_d   = '0;
            dur_d   = DUR_END;
            tcnt_d  = 3'd0;
        end else begin
            state_d = state_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            voice_q <= 2'b00;
            odn_q   <= 1'b0;
            oup_q   <= 1'b0;
            trem_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            dur_q   <= 3'd0;
            tcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            voice_q <= voice_d;
            odn_q   <= odn_d;
            oup_q   <= oup_d;
            trem_q  <= trem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign voice_en    = voice_q;
    assign octave_dena = odn_q;
    assign octave_uena = oup_q;
    assign tremolo_ena = trem_q;
    assign busy        = busy_q;
    assign step_idx    = idx_q;
    assign done        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer (DEPTH=4, TICK_DIV=4): table vectors, directed
// corner sequences and randomized patterns against a trace-building reference model.
module tb_note_sequencer;

    localparam int DEPTH = 4;
    localparam int TD    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       loop_en = 1'b0;
    logic [1:0] voice_en;
    logic       octave_dena, octave_uena, tremolo_ena, busy, done;
    logic [1:0] step_idx;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [1:0] voice;
        logic       odn;
        logic       oup;
        logic       trem;
        logic       busy;
        logic       done;
        logic [1:0] idx;
    } rec_t;

    typedef struct {
        logic [7:0] word;
        logic [1:0] voice;
        logic       odn;
        logic       oup;
        logic       trem;
        int         len;
    } vec_t;

    vec_t       tbl [7];
    logic [7:0] model_mem [DEPTH];
    rec_t       exp_q [$];

    note_sequencer #(.DEPTH(DEPTH), .TICK_DIV(TD)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .stop(stop), .loop_en(loop_en), .voice_en(voice_en),
        .octave_dena(octave_dena), .octave_uena(octave_uena), .tremolo_ena(tremolo_ena),
        .busy(busy), .step_idx(step_idx), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog time limit expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic rec_t mk(logic [1:0] v, logic od, logic ou, logic tr, logic b, logic d, logic [1:0] ix);
        rec_t r;
        r.voice = v; r.odn = od; r.oup = ou; r.trem = tr; r.busy = b; r.done = d; r.idx = ix;
        return r;
    endfunction

    function automatic rec_t idle_rec(logic d);
        return mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, d, 2'd0);
    endfunction

    // Outputs a sounding step word should produce, straight from the field definitions.
    function automatic rec_t word_rec(logic [7:0] w, logic [1:0] ix);
        return mk(w[7:6], w[5] & ~w[4], w[4] & ~w[5], w[3], 1'b1, 1'b0, ix);
    endfunction

    function automatic rec_t cur();
        return mk(voice_en, octave_dena, octave_uena, tremolo_ena, busy, done, step_idx);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input rec_t e);
        rec_t a;
        a = cur();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got{v,od,ou,tr,busy,done,idx}=%b_%b_%b_%b_%b_%b_%0d want=%b_%b_%b_%b_%b_%b_%0d",
                     nm, a.voice, a.odn, a.oup, a.trem, a.busy, a.done, a.idx,
                     e.voice, e.odn, e.oup, e.trem, e.busy, e.done, e.idx);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, a, e);
        end
    endtask

    task automatic write_slot(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a[1:0]; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic play_len(output int n, output logic [1:0] last_v);
        n = 0;
        last_v = 2'b00;
        while (busy === 1'b1 && n < 100) begin
            last_v = voice_en;
            n++;
            cyc();
        end
    endtask

    // Expected per-cycle trace after the start edge: steps back to back, then a done cycle
    // (one-shot) or a restart at slot 0 (loop) until at least ncyc cycles are described.
    task automatic build_trace(input logic lp, input int ncyc);
        int   d;
        rec_t r;
        exp_q.delete();
        if (model_mem[0][2:0] == 3'd0) begin
            exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
            if (lp) begin
                while (exp_q.size() < ncyc) exp_q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
            end else begin
                exp_q.push_back(idle_rec(1'b1));
            end
            return;
        end
        while (exp_q.size() < ncyc) begin
            for (int i = 0; i < DEPTH; i++) begin
                d = int'(model_mem[i][2:0]);
                if (d == 0) break;
                for (int c = 0; c < d * TD; c++) begin
                    r = word_rec(model_mem[i], i[1:0]);
`ifdef NOTE_SEQ_ARTIC_EN
                    if (d >= 2 && c >= (d - 1) * TD) r.voice = 2'b00;
`endif
                    exp_q.push_back(r);
                end
            end
            if (!lp) begin
                exp_q.push_back(idle_rec(1'b1));
                break;
            end
        end
    endtask

    initial begin
        int         n;
        int         len;
        int         stop_at;
        logic       lp;
        logic       stopped;
        logic [1:0] lv;
        logic [1:0] exp_last;
        logic [1:0] v42;
        logic [7:0] w;

        tbl[0] = '{8'h4A, 2'b01, 1'b0, 1'b0, 1'b1, 8};
        tbl[1] = '{8'h91, 2'b10, 1'b0, 1'b1, 1'b0, 4};
        tbl[2] = '{8'h62, 2'b01, 1'b1, 1'b0, 1'b0, 8};
        tbl[3] = '{8'h3A, 2'b00, 1'b0, 1'b0, 1'b1, 8};
        tbl[4] = '{8'hC7, 2'b11, 1'b0, 1'b0, 1'b0, 28};
        tbl[5] = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1};
        tbl[6] = '{8'hE9, 2'b11, 1'b1, 1'b0, 1'b1, 4};

        // Reset while inputs toggle randomly.
        wr_en = 1'($urandom); start = 1'($urandom); stop = 1'($urandom);
        loop_en = 1'($urandom); wr_data = 8'($urandom); wr_addr = 2'($urandom);
        cyc();
        cyc();
        chk("reset_state", idle_rec(1'b0));
        wr_en = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        rst = 1'b0;
        cyc();
        chk("after_reset", idle_rec(1'b0));

        // Single-step patterns from the vector table.
        for (int t = 0; t < 7; t++) begin
            write_slot(0, tbl[t].word);
            write_slot(1, 8'h00);
            do_start();
            chk($sformatf("tbl%0d_first", t),
                mk(tbl[t].voice, tbl[t].odn, tbl[t].oup, tbl[t].trem, 1'b1, 1'b0, 2'd0));
            play_len(n, lv);
            chk_int($sformatf("tbl%0d_len", t), n, tbl[t].len);
            chk($sformatf("tbl%0d_done", t), idle_rec(1'b1));
            exp_last = tbl[t].voice;
`ifdef NOTE_SEQ_ARTIC_EN
            if (tbl[t].word[2:0] >= 3'd2) exp_last = 2'b00;
`endif
            chk_int($sformatf("tbl%0d_last_voice", t), int'(lv), int'(exp_last));
            cyc();
            chk($sformatf("tbl%0d_done_once", t), idle_rec(1'b0));
        end

        // Looping two-step pattern, a dropped mid-play write, then stop inside step 1.
        write_slot(0, 8'h91);
        write_slot(1, 8'h62);
        write_slot(2, 8'h00);
        loop_en = 1'b1;
        do_start();
        for (int rep = 0; rep < 3; rep++) begin
            for (int c = 0; c < 4; c++) begin
                chk($sformatf("loop_r%0d_s0", rep), mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
                if (rep == 2 && c == 0) begin
                    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hC7;
                end
                cyc();
                wr_en = 1'b0;
            end
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("loop_r%0d_s1", rep), mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
                cyc();
            end
        end
        for (int c = 0; c < 4; c++) begin
            chk("stop_s0", mk(2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
            cyc();
        end
        for (int c = 0; c < 3; c++) begin
            chk("stop_s1", mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
            if (c == 2) stop = 1'b1;
            cyc();
        end
        stop = 1'b0;
        chk("stop_idle", idle_rec(1'b0));
        cyc();
        chk("stop_no_done", idle_rec(1'b0));
        loop_en = 1'b0;
        do_start();
        chk("replay_slot0_kept", word_rec(8'h91, 2'd0));
        play_len(n, lv);
        chk_int("replay_len", n, 12);
        chk("replay_done", idle_rec(1'b1));
        cyc();

        // start and stop together from idle: stop wins.
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_idle", idle_rec(1'b0));
        cyc();
        chk("start_stop_idle2", idle_rec(1'b0));

        // Two-tick step: articulation gap on the final tick when enabled.
        write_slot(0, 8'h42);
        write_slot(1, 8'h00);
        do_start();
        v42 = 2'b01;
`ifdef NOTE_SEQ_ARTIC_EN
        v42 = 2'b00;
`endif
        for (int c = 0; c < 8; c++) begin
            chk("artic_step", mk((c < 4) ? 2'b01 : v42, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0));
            cyc();
        end
        chk("artic_done", idle_rec(1'b1));
        cyc();

        // Asynchronous reset mid-play clears outputs without waiting for an edge.
        write_slot(0, 8'h4A);
        do_start();
        cyc();
        chk("pre_async_rst", word_rec(8'h4A, 2'd0));
        rst = 1'b1;
        #1;
        chk("async_rst", idle_rec(1'b0));
        cyc();
        rst = 1'b0;
        cyc();
        chk("async_rst_held_idle", idle_rec(1'b0));

        // Randomized patterns against the trace model.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                w = 8'($urandom);
                w[2:0] = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(1, 3));
                model_mem[i] = w;
                write_slot(i, w);
            end
            lp = 1'($urandom_range(0, 1));
            loop_en = lp;
            build_trace(lp, 48);
            len = lp ? 48 : exp_q.size();
            if (lp) stop_at = $urandom_range(0, 47);
            else stop_at = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
            stopped = 1'b0;
            do_start();
            for (int k = 0; k < len; k++) begin
                chk($sformatf("rand%0d_k%0d", r, k), exp_q[k]);
                if (k == stop_at) begin
                    stop = 1'b1;
                    cyc();
                    stop = 1'b0;
                    chk($sformatf("rand%0d_stop", r), idle_rec(1'b0));
                    stopped = 1'b1;
                    break;
                end
                cyc();
            end
            if (!stopped) chk($sformatf("rand%0d_end_idle", r), idle_rec(1'b0));
            loop_en = 1'b0;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Pattern sequencer that drives the tone-feature block's control inputs: voice enables (the two tone clocks), octave-down, octave-up and tremolo. A host loads up to DEPTH steps into an internal step memory, then pulses `start`. The block plays each step for a programmed number of tempo ticks and optionally loops. It sits between the pin interface and the tone-feature instance, so the performer no longer toggles feature pins by hand.

## Interface
- `DEPTH`, 16: number of step slots; power of two, 2..16.
- `TICK_DIV`, 1000: clk cycles per tempo tick; minimum 2.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  step-memory write strobe.
- `wr_addr`  in  $clog2(DEPTH)  step slot to write.
- `wr_data`  in  8  step word: [7:6] voice, [5] oct_down, [4] oct_up, [3] tremolo, [2:0] duration in ticks.
- `start`  in  1  begin playback at step 0.
- `stop`  in  1  abort playback.
- `loop_en`  in  1  restart at step 0 at end of pattern instead of finishing.
- `voice_en`  out  2  bit0 gates tone clock 1, bit1 gates tone clock 2.
- `octave_dena`  out  1  octave-down enable.
- `octave_uena`  out  1  octave-up enable.
- `tremolo_ena`  out  1  tremolo enable.
- `busy`  out  1  high in PLAY.
- `step_idx`  out  $clog2(DEPTH)  index of the step currently sounding.
- `done`  out  1  one-cycle pulse on natural pattern end.

## Operation
- States: IDLE, PLAY. Reset enters IDLE; every output is 0 and `step_idx` is 0. Step memory is not reset.
- Writes are accepted in IDLE only. A write in PLAY is silently dropped.
- Voice field: 00 = rest, 01 = clock 1, 10 = clock 2, 11 = both.
- If oct_down and oct_up are both set, both outputs are driven 0 (normal octave).
- A duration of 0 marks the end of the pattern. That step does not sound.
- IDLE→PLAY occurs on `start` when `stop`=0. The tick prescaler and the duration counter clear, and step 0 is fetched.
- In PLAY, each step holds its outputs for duration×TICK_DIV cycles, then advances to the next index.
- End of pattern is either an end marker or completion of index DEPTH-1. At end of pattern:
  - If `loop_en`=1 (sampled that cycle): continue at step 0, with no gap cycle.
  - Otherwise: go to IDLE, pulse `done` for one cycle, and clear all outputs.
- `stop` in PLAY: go to IDLE next cycle, clear outputs, and do not pulse `done`.
- `start` in PLAY is ignored. If `start` and `stop` are asserted in the same cycle, `stop` wins.
- Step 0 is an end marker: PLAY lasts one cycle with outputs 0. `done` pulses, and with `loop_en`=1 playback remains in PLAY, silent.
- Counter widths: prescaler $clog2(TICK_DIV) bits, wrapping at TICK_DIV-1. Duration counter is 3 bits. Step index wraps modulo DEPTH.

## Timing
- All outputs are registered.
- Step 0 outputs appear on the first edge after the `start` edge, i.e. 1 cycle of latency.
- Each step occupies exactly duration×TICK_DIV cycles of output.
- The step transition is seamless: the next step's outputs appear on the cycle after the previous step's last cycle.
- `done` is asserted in the same cycle that `busy` falls.
- `stop` and reset are observed on the first output edge after them; reset acts asynchronously.

## Configuration
- `NOTE_SEQ_ARTIC_EN` defined: on the final tick of any step with duration ≥2, `voice_en` is forced to 00 (an articulation gap). Octave and tremolo are held.
- Undefined: voices sound continuously for the full step.
- Step timing is identical in both builds.

## Structure
- Package `note_seq_pkg`:
  - state enum,
  - step-field bit positions,
  - voice encodings,
  - end-marker constant (duration 0).
- Sub-module `seq_tick_gen`: a TICK_DIV prescaler with a synchronous clear, producing a one-cycle `tick` pulse.
- Step memory is a flop array inside `note_sequencer`.

## Test plan
TICK_DIV=4 for all tests.
- Reset with random inputs → all outputs 0, `busy`=0, `step_idx`=0.
- Write slot0=0x4A and slot1=0x00, pulse `start` → `voice_en`=01 and `tremolo_ena`=1 for 8 cycles starting 1 cycle after `start`, then `done` pulses and `busy` falls in the same cycle.
- Load slot0=0x91, slot1=0x62, slot2=0x00 with `loop_en`=1, then start.
  - Expected sequence: `voice_en`=10 with `octave_dena`=0 and `octave_uena`=1 for 4 cycles, then 01 with `octave_dena`=1 for 8 cycles, then repeats.
  - `done` is never asserted.
- Assert `stop` at cycle 3 of step 1 → outputs 0 and `busy`=0 next cycle, no `done`. A write issued mid-play is dropped (read back via replay).
- Assert `start` and `stop` in the same cycle from IDLE → remains IDLE.
- Load slot0=0x3A (both octave bits set) → `octave_dena`=`octave_uena`=0.
- With `NOTE_SEQ_ARTIC_EN` and slot0=0x42 → `voice_en`=01 for 4 cycles, then 00 for 4 cycles, with `busy` high throughout.
